rot_input_conditioner: RTL and testbench



---
 rtl/rot_input_conditioner.sv | 82 ++++++++
 tb/tb_rot_input_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rot_input_conditioner.sv
// rot_input_conditioner: synchronise and debounce raw encoder/button pins for the rotary counter
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous active-high reset
//   ROTa_pin   in   raw encoder A (async)
//   ROTb_pin   in   raw encoder B (async)
//   BTN_W_pin  in   raw west button, 1 = pressed (async)
//   BTN_C_pin  in   raw centre push, 1 = pressed (async)
//   ROTa       out  debounced A
//   ROTb       out  debounced B
//   BTN_W      out  debounced west button
//   cfg        out  encoder direction flag
//   press      out  one-cycle pulse per accepted centre press
//
// Optional feature: define ROT_CFG_TOGGLE_EN to make each centre press toggle cfg;
// otherwise cfg is the constant CFG_DEFAULT.
module rot_input_conditioner #(
    parameter int   ROT_DB      = 16,
    parameter int   BTN_DB      = 50000,
    parameter logic CFG_DEFAULT = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic ROTa_pin,
    input  logic ROTb_pin,
    input  logic BTN_W_pin,
    input  logic BTN_C_pin,
    output logic ROTa,
    output logic ROTb,
    output logic BTN_W,
    output logic cfg,
    output logic press
);
    // Channel order: 0 = A, 1 = B, 2 = west button, 3 = centre button.
    // The centre filter resets to 1 so a button held through reset is not seen as a press.
    localparam logic [3:0] Q_RST = 4'b1000;
    logic [3:0] w_pin, r_s1, r_s2, r_q, w_take;
    logic       w_rise, r_press;
    assign w_pin = {BTN_C_pin, BTN_W_pin, ROTb_pin, ROTa_pin};
    for (genvar i = 0; i < 4; i++) begin : g_ch
        localparam int LIM = (i < 2) ? ROT_DB : BTN_DB;
        localparam int W   = $clog2(LIM);
        logic [W-1:0] r_cnt;
        // Accept the new level once it has been stable for LIM consecutive filter cycles.
        assign w_take[i] = (r_s2[i] != r_q[i]) && (r_cnt == W'(LIM - 1));
        always_ff @(posedge clk or posedge reset)
            if (reset)
                r_cnt <= '0;
            else
                r_cnt <= (r_s2[i] == r_q[i] || w_take[i]) ? '0 : r_cnt + 1'b1;
    end
    assign w_rise = w_take[3] & r_s2[3];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_q     <= Q_RST;
            r_press <= 1'b0;
        end else begin
            r_s1    <= w_pin;
            r_s2    <= r_s1;
            // A take always means s2 differs from q, so accepting is a flip.
            r_q     <= r_q ^ w_take;
            r_press <= w_rise;
        end
`ifdef ROT_CFG_TOGGLE_EN
    logic r_cfg;
    always_ff @(posedge clk or posedge reset)
        if (reset)
            r_cfg <= CFG_DEFAULT;
        else if (w_rise)
            r_cfg <= ~r_cfg;
    assign cfg = r_cfg;
`else
    assign cfg = CFG_DEFAULT;
`endif
    assign ROTa  = r_q[0];
    assign ROTb  = r_q[1];
    assign BTN_W = r_q[2];
    assign press = r_press;
endmodule

// File: tb/tb_rot_input_conditioner.sv
// tb_rot_input_conditioner: directed self-checking bench for rot_input_conditioner
module tb_rot_input_conditioner;
    localparam int   ROT_DB = 16;
    localparam int   BTN_DB = 200;
    localparam logic CFG_D  = 1'b1;
`ifdef ROT_CFG_TOGGLE_EN
    localparam logic TOG = 1'b1;
`else
    localparam logic TOG = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1;
    logic ROTa_pin = 1'b0, ROTb_pin = 1'b0, BTN_W_pin = 1'b0, BTN_C_pin = 1'b0;
    logic ROTa, ROTb, BTN_W, cfg, press;
    int   n_checks = 0, n_fail = 0, press_cnt = 0, base = 0;
    logic exp_cfg = CFG_D;

    rot_input_conditioner #(.ROT_DB(ROT_DB), .BTN_DB(BTN_DB), .CFG_DEFAULT(CFG_D)) dut (
        .clk(clk), .reset(reset),
        .ROTa_pin(ROTa_pin), .ROTb_pin(ROTb_pin), .BTN_W_pin(BTN_W_pin), .BTN_C_pin(BTN_C_pin),
        .ROTa(ROTa), .ROTb(ROTb), .BTN_W(BTN_W), .cfg(cfg), .press(press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (press === 1'b1) press_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        ticks(3);
        n_checks++; if (ROTa !== 1'b0) begin n_fail++; $display("FAIL reset_rota: got %b want 0", ROTa); end
        n_checks++; if (ROTb !== 1'b0) begin n_fail++; $display("FAIL reset_rotb: got %b want 0", ROTb); end
        n_checks++; if (BTN_W !== 1'b0) begin n_fail++; $display("FAIL reset_btnw: got %b want 0", BTN_W); end
        n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL reset_press: got %b want 0", press); end
        n_checks++; if (cfg !== CFG_D) begin n_fail++; $display("FAIL reset_cfg: got %b want %b", cfg, CFG_D); end
        reset = 1'b0;
    endtask

    task automatic test_rot_rise;
        ticks(5);
        ROTa_pin = 1'b1;
        ticks(17);
        n_checks++; if (ROTa !== 1'b0) begin n_fail++; $display("FAIL rota_early: got %b want 0", ROTa); end
        ticks(1);
        n_checks++; if (ROTa !== 1'b1) begin n_fail++; $display("FAIL rota_rise: got %b want 1", ROTa); end
        n_checks++; if (ROTb !== 1'b0) begin n_fail++; $display("FAIL rotb_quiet: got %b want 0", ROTb); end
        n_checks++; if (BTN_W !== 1'b0) begin n_fail++; $display("FAIL btnw_quiet: got %b want 0", BTN_W); end
        n_checks++; if (press_cnt !== 0) begin n_fail++; $display("FAIL press_quiet: got %0d want 0", press_cnt); end
    endtask

    task automatic test_rot_glitch;
        ROTa_pin = 1'b0;
        ticks(15);
        ROTa_pin = 1'b1;
        ticks(30);
        n_checks++; if (ROTa !== 1'b1) begin n_fail++; $display("FAIL glitch15: got %b want 1", ROTa); end
        ROTa_pin = 1'b0;
        ticks(17);
        n_checks++; if (ROTa !== 1'b1) begin n_fail++; $display("FAIL fall_early: got %b want 1", ROTa); end
        ticks(1);
        n_checks++; if (ROTa !== 1'b0) begin n_fail++; $display("FAIL fall16: got %b want 0", ROTa); end
    endtask

    task automatic test_west;
        BTN_W_pin = 1'b1;
        ticks(201);
        n_checks++; if (BTN_W !== 1'b0) begin n_fail++; $display("FAIL btnw_early: got %b want 0", BTN_W); end
        ticks(1);
        n_checks++; if (BTN_W !== 1'b1) begin n_fail++; $display("FAIL btnw_rise: got %b want 1", BTN_W); end
        n_checks++; if (press_cnt !== 0) begin n_fail++; $display("FAIL west_no_press: got %0d want 0", press_cnt); end
    endtask

    task automatic test_press;
        ticks(50);
        base = press_cnt;
        for (int b = 0; b < 3; b++) begin
            BTN_C_pin = 1'b1; ticks(20);
            BTN_C_pin = 1'b0; ticks(20);
        end
        BTN_C_pin = 1'b1;
        ticks(201);
        n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL press_early: got %b want 0", press); end
        n_checks++; if (press_cnt !== base) begin n_fail++; $display("FAIL bounce_count: got %0d want %0d", press_cnt, base); end
        ticks(1);
        exp_cfg = exp_cfg ^ TOG;
        n_checks++; if (press !== 1'b1) begin n_fail++; $display("FAIL press_edge: got %b want 1", press); end
        n_checks++; if (cfg !== exp_cfg) begin n_fail++; $display("FAIL cfg_toggle1: got %b want %b", cfg, exp_cfg); end
        ticks(1);
        n_checks++; if (press !== 1'b0) begin n_fail++; $display("FAIL press_width: got %b want 0", press); end
        ticks(300);
        n_checks++; if (press_cnt !== base + 1) begin n_fail++; $display("FAIL press_once: got %0d want %0d", press_cnt, base + 1); end
        BTN_C_pin = 1'b0;
        ticks(250);
        n_checks++; if (press_cnt !== base + 1) begin n_fail++; $display("FAIL release_quiet: got %0d want %0d", press_cnt, base + 1); end
        n_checks++; if (cfg !== exp_cfg) begin n_fail++; $display("FAIL release_cfg: got %b want %b", cfg, exp_cfg); end
        BTN_C_pin = 1'b1;
        ticks(250);
        exp_cfg = exp_cfg ^ TOG;
        n_checks++; if (press_cnt !== base + 2) begin n_fail++; $display("FAIL press_second: got %0d want %0d", press_cnt, base + 2); end
        n_checks++; if (cfg !== exp_cfg) begin n_fail++; $display("FAIL cfg_toggle2: got %b want %b", cfg, exp_cfg); end
    endtask

    task automatic test_hold_reset;
        reset = 1'b1;
        ticks(3);
        n_checks++; if (cfg !== CFG_D) begin n_fail++; $display("FAIL hold_rst_cfg: got %b want %b", cfg, CFG_D); end
        reset = 1'b0;
        exp_cfg = CFG_D;
        base = press_cnt;
        ticks(300);
        n_checks++; if (press_cnt !== base) begin n_fail++; $display("FAIL held_no_press: got %0d want %0d", press_cnt, base); end
        n_checks++; if (cfg !== CFG_D) begin n_fail++; $display("FAIL held_cfg: got %b want %b", cfg, CFG_D); end
        BTN_C_pin = 1'b0;
        ticks(250);
        BTN_C_pin = 1'b1;
        ticks(250);
        exp_cfg = exp_cfg ^ TOG;
        n_checks++; if (press_cnt !== base + 1) begin n_fail++; $display("FAIL after_hold_press: got %0d want %0d", press_cnt, base + 1); end
        n_checks++; if (cfg !== exp_cfg) begin n_fail++; $display("FAIL after_hold_cfg: got %b want %b", cfg, exp_cfg); end
    endtask

    task automatic test_async_reset;
        ROTb_pin = 1'b1;
        ticks(18);
        n_checks++; if (ROTb !== 1'b1) begin n_fail++; $display("FAIL rotb_rise: got %b want 1", ROTb); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_checks++; if (ROTb !== 1'b0) begin n_fail++; $display("FAIL async_rotb: got %b want 0", ROTb); end
        n_checks++; if (BTN_W !== 1'b0) begin n_fail++; $display("FAIL async_btnw: got %b want 0", BTN_W); end
        n_checks++; if (cfg !== CFG_D) begin n_fail++; $display("FAIL async_cfg: got %b want %b", cfg, CFG_D); end
        @(posedge clk);
        #1 reset = 1'b0;
        ticks(17);
        n_checks++; if (ROTb !== 1'b0) begin n_fail++; $display("FAIL post_rst_early: got %b want 0", ROTb); end
        ticks(1);
        n_checks++; if (ROTb !== 1'b1) begin n_fail++; $display("FAIL post_rst_rise: got %b want 1", ROTb); end
    endtask

    initial begin
        test_reset;
        test_rot_rise;
        test_rot_glitch;
        test_west;
        test_press;
        test_hold_reset;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
